// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, bubble
// encoding, fetch state encoding and IF/ID field widths.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  // Bubble instruction: addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR_ENC = 32'h0000_0013;

  // IF/ID pipeline register field widths
  localparam int IFID_PC_W    = XLEN;
  localparam int IFID_INSTR_W = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A bubble has priority over a load; with neither
// asserted every field holds, which is how a stall freezes the register.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [IFID_INSTR_W-1:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    bubble,
  input  logic [IFID_PC_W-1:0]    pc_in,
  input  logic [IFID_INSTR_W-1:0] instr_in,
  input  logic [IFID_PC_W-1:0]    pc_plus4_in,
  output logic [IFID_PC_W-1:0]    ifid_pc,
  output logic [IFID_INSTR_W-1:0] ifid_instr,
  output logic [IFID_PC_W-1:0]    ifid_pc_plus4,
  output logic                    ifid_valid
);

  // Register update: reset/bubble insert a NOP, load captures the fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_pc       <= '0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (bubble) begin
      ifid_pc       <= '0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (load) begin
      ifid_pc       <= pc_in;
      ifid_instr    <= instr_in;
      ifid_pc_plus4 <= pc_plus4_in;
      ifid_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and RUN/HALTED
// control feeding the IF/ID register.
// Optional build macro IF_MISALIGN_CHECK_EN: adds misalign_err and halts on a
// redirect to a non-word-aligned target instead of masking the low bits.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     MEM_WORDS = 1024,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic            ifid_valid,
  output logic            halted
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  // One extra bit so a full 4 GiB image size cannot overflow the bound
  localparam logic [XLEN:0] MEM_BYTES = {1'b0, XLEN'(MEM_WORDS)} << 2;

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_aligned;
  logic            out_of_range;
  logic            redirect_bad;
  logic            ifid_load, ifid_bubble;

  assign imem_pc        = pc_reg;
  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};
  assign out_of_range   = ({1'b0, pc_reg} >= MEM_BYTES);
  assign halted         = (state_reg == HALTED);

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_reg;

  assign redirect_bad = redirect && (redirect_target[1:0] != 2'b00);
  assign misalign_err = misalign_reg;

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_reg <= 1'b0;
    else       misalign_reg <= misalign_reg | redirect_bad;
  end
`else
  // Target low bits are simply dropped in this build
  logic unused_target_lsbs;
  assign redirect_bad       = 1'b0;
  assign unused_target_lsbs = ^redirect_target[1:0];
`endif

  // State and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-PC, next-state and IF/ID control in priority order
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state_reg)
      RUN: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          if (redirect_bad) state_next = HALTED;
          else              pc_next    = target_aligned;
        end else if (!stall) begin
          if (out_of_range) begin
            ifid_bubble = 1'b1;
            pc_next     = pc_plus4;
          end else if (imem_instr == 32'h0) begin
            // End of program image: stop without advancing the PC
            ifid_bubble = 1'b1;
            state_next  = HALTED;
          end else begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4;
          end
        end
      end
      HALTED: begin
        // Bubbles every cycle; only a good redirect restarts fetch
        ifid_bubble = 1'b1;
        if (redirect && !redirect_bad) begin
          pc_next    = target_aligned;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .pc_in         (pc_reg),
    .instr_in      (imem_instr),
    .pc_plus4_in   (pc_plus4),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
  );

endmodule
